// File: rtl/fetch_prefetch_buf.sv
// fetch_prefetch_buf
//   Sequential instruction-fetch stage sitting in front of a single-port word
//   memory with 1-cycle read latency. Issues word-aligned reads ahead of the
//   consumer, buffers returned words in a DEPTH-entry FIFO, and hands them to
//   the core over valid/ready. A redirect flushes the FIFO and drops any data
//   still in flight.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   branch_i              redirect pulse
//   branch_addr_i         redirect target (low two bits ignored)
//   ready_i               consumer takes the head word this cycle
//   valid_o               head word available
//   rdata_o, addr_o       head word data and its byte address
//   mem_req_o             read request to memory
//   mem_addr_o            word-aligned request address
//   mem_rvalid_i          read response valid (one cycle after the request)
//   mem_rdata_i           read response data

module fetch_prefetch_buf #(
    parameter int          DEPTH      = 2,
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] rdata_o,
    output logic [31:0] addr_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int UW = CW + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [31:0]   START   = RESET_ADDR & 32'hFFFF_FFFC;

    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_addr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          outstanding;
    logic          discard;
    logic [31:0]   fetch_addr;
    logic [31:0]   inflight_addr;
    logic [31:0]   head_data;
    logic [31:0]   head_addr;

    logic          pop;
    logic          push;
    logic [UW-1:0] used;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] remaining;
    logic          head_load;
    logic [31:0]   head_data_next;
    logic [31:0]   head_addr_next;
    logic [31:0]   target;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign valid_o    = (count != '0);
    assign rdata_o    = head_data;
    assign addr_o     = head_addr;
    assign mem_addr_o = fetch_addr;
    assign target     = branch_addr_i & 32'hFFFF_FFFC;

    assign pop  = valid_o && ready_i;
    // Responses only count when a request is actually outstanding; this is
    // what drops a response landing in the first cycle after reset.
    assign push = mem_rvalid_i && outstanding && !discard;

    // Credits: buffered words plus the in-flight one, minus the word leaving now.
    assign used      = UW'(count) + UW'(outstanding) - UW'(pop);
    assign mem_req_o = !rst_i && !branch_i && (used < DEPTH_U);

    // Head registers preload whatever will sit at the FIFO head after this
    // edge, so rdata_o/addr_o come straight from flops and hold when empty.
    always_comb begin
        rd_next        = pop ? ptr_inc(rd_ptr) : rd_ptr;
        remaining      = count - CW'(pop);
        head_load      = 1'b0;
        head_data_next = head_data;
        head_addr_next = head_addr;
        if (remaining != '0) begin
            head_load      = 1'b1;
            head_data_next = fifo_data[rd_next];
            head_addr_next = fifo_addr[rd_next];
        end else if (push) begin
            head_load      = 1'b1;
            head_data_next = mem_rdata_i;
            head_addr_next = inflight_addr;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
            outstanding   <= 1'b0;
            discard       <= 1'b0;
            fetch_addr    <= START;
            inflight_addr <= '0;
            head_data     <= '0;
            head_addr     <= '0;
        end else begin
            outstanding <= mem_req_o;
            if (mem_req_o) begin
                fetch_addr    <= fetch_addr + 32'd4;
                inflight_addr <= fetch_addr;
            end
            if (branch_i) begin
                // Redirect wins over push and pop; the head registers keep
                // their last value while the FIFO is empty.
                rd_ptr     <= '0;
                wr_ptr     <= '0;
                count      <= '0;
                fetch_addr <= target;
                discard    <= outstanding;
            end else begin
                discard <= 1'b0;
                if (push) begin
                    fifo_data[wr_ptr] <= mem_rdata_i;
                    fifo_addr[wr_ptr] <= inflight_addr;
                    wr_ptr            <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= rd_next;
                end
                case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
                if (head_load) begin
                    head_data <= head_data_next;
                    head_addr <= head_addr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buf.sv
module tb_fetch_prefetch_buf;

    localparam logic [31:0] RST_A = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        branch_i;
    logic [31:0] branch_addr_i;
    logic        ready_i;
    logic        valid_o;
    logic [31:0] rdata_o;
    logic [31:0] addr_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        inject;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_fetch;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];

    fetch_prefetch_buf #(.DEPTH(2), .RESET_ADDR(RST_A)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .branch_i     (branch_i),
        .branch_addr_i(branch_addr_i),
        .ready_i      (ready_i),
        .valid_o      (valid_o),
        .rdata_o      (rdata_o),
        .addr_o       (addr_o),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_rdata_i  (mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Memory: word at byte address a holds A000_0000 + a/4. inject forces a
    // bogus response with no matching request.
    always @(posedge clk_i) begin
        mem_rvalid_i <= mem_req_o | inject;
        mem_rdata_i  <= mem_req_o ? 32'hA000_0000 + {2'b00, mem_addr_o[31:2]} : 32'hDEAD_BEEF;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA000_0000 + {2'b00, a[31:2]};
    endfunction

    // Scoreboard: expected words are queued when a request is issued and
    // compared while they sit at the head of the DUT output.
    always @(negedge clk_i) begin
        if (rst_i) begin
            chk("req_in_reset", {31'd0, mem_req_o}, 32'd0);
            q_addr.delete();
            q_data.delete();
            exp_fetch = RST_A;
        end else begin
            if (branch_i) chk("req_in_branch", {31'd0, mem_req_o}, 32'd0);
            if (valid_o) begin
                if (q_addr.size() == 0) begin
                    chk("unexpected_word", {31'd0, valid_o}, 32'd0);
                end else begin
                    chk("sb_addr", addr_o, q_addr[0]);
                    chk("sb_data", rdata_o, q_data[0]);
                    if (ready_i) begin
                        void'(q_addr.pop_front());
                        void'(q_data.pop_front());
                    end
                end
            end
            if (branch_i) begin
                q_addr.delete();
                q_data.delete();
                exp_fetch = branch_addr_i & 32'hFFFF_FFFC;
            end else if (mem_req_o) begin
                chk("req_addr", mem_addr_o, exp_fetch);
                q_addr.push_back(exp_fetch);
                q_data.push_back(mem_word(exp_fetch));
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int  n_req;
        bit  found;
        logic [31:0] e;

        rst_i = 1'b1; ready_i = 1'b1; branch_i = 1'b0; branch_addr_i = '0; inject = 1'b0;

        // reset and streaming start-up
        step(); step();
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_req",   {31'd0, mem_req_o}, 32'd0);
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_addr",  addr_o, 32'd0);
        rst_i = 1'b0; #1;
        chk("c1_req",   {31'd0, mem_req_o}, 32'd1);
        chk("c1_maddr", mem_addr_o, 32'h100);
        chk("c1_valid", {31'd0, valid_o}, 32'd0);
        step();
        chk("c2_valid", {31'd0, valid_o}, 32'd0);
        chk("c2_maddr", mem_addr_o, 32'h104);
        step();
        chk("c3_valid", {31'd0, valid_o}, 32'd1);
        chk("c3_addr",  addr_o, 32'h100);
        for (int k = 1; k <= 5; k++) begin
            step();
            chk("stream_valid", {31'd0, valid_o}, 32'd1);
            chk("stream_addr", addr_o, 32'h100 + 32'(4 * k));
        end

        // stall with ready low from the first cycle
        rst_i = 1'b1; ready_i = 1'b0;
        step();
        rst_i = 1'b0;
        n_req = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (mem_req_o) n_req++;
            step();
        end
        chk("stall_req_count", 32'(n_req), 32'd2);
        #1;
        chk("stall_req_off", {31'd0, mem_req_o}, 32'd0);
        chk("stall_valid",   {31'd0, valid_o}, 32'd1);
        chk("stall_head",    addr_o, 32'h100);
        ready_i = 1'b1; #1;
        chk("resume_req",   {31'd0, mem_req_o}, 32'd1);
        chk("resume_maddr", mem_addr_o, 32'h108);
        step();
        chk("resume_head", addr_o, 32'h104);

        // redirect while 0x10C is in flight; also pop+push at the branch edge
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_req_o && mem_addr_o == 32'h10C) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("find_10c", {31'd0, found}, 32'd1);
        step();
        branch_i = 1'b1; branch_addr_i = 32'h2003; #1;
        chk("br_valid_before", {31'd0, valid_o}, 32'd1);
        chk("br_req", {31'd0, mem_req_o}, 32'd0);
        step();
        branch_i = 1'b0; #1;
        chk("br_flushed", {31'd0, valid_o}, 32'd0);
        chk("br_req1",    {31'd0, mem_req_o}, 32'd1);
        chk("br_maddr",   mem_addr_o, 32'h2000);
        step();
        chk("br_n2_valid", {31'd0, valid_o}, 32'd0);
        step();
        chk("br_n3_valid", {31'd0, valid_o}, 32'd1);
        chk("br_n3_addr",  addr_o, 32'h2000);
        chk("br_n3_data",  rdata_o, 32'hA000_0800);

        // address wrap
        branch_i = 1'b1; branch_addr_i = 32'hFFFF_FFF8;
        step();
        branch_i = 1'b0;
        step(); step();
        for (int k = 0; k < 4; k++) begin
            e = 32'hFFFF_FFF8 + 32'(4 * k);
            chk("wrap_valid", {31'd0, valid_o}, 32'd1);
            chk("wrap_addr", addr_o, e);
            step();
        end

        // reset with one word buffered and one request in flight
        ready_i = 1'b0; branch_i = 1'b1; branch_addr_i = 32'h3000;
        step();
        branch_i = 1'b0;
        step(); step();
        chk("pre_rst_valid", {31'd0, valid_o}, 32'd1);
        chk("pre_rst_req",   {31'd0, mem_req_o}, 32'd0);
        rst_i = 1'b1;
        step();
        chk("mid_rst_valid", {31'd0, valid_o}, 32'd0);
        chk("mid_rst_req",   {31'd0, mem_req_o}, 32'd0);
        inject = 1'b1;
        step();
        rst_i = 1'b0; inject = 1'b0; #1;
        chk("post_rst_req",   {31'd0, mem_req_o}, 32'd1);
        chk("post_rst_maddr", mem_addr_o, RST_A);
        chk("post_rst_valid", {31'd0, valid_o}, 32'd0);
        step();
        chk("stale_ignored", {31'd0, valid_o}, 32'd0);
        step();
        chk("post_rst_head_valid", {31'd0, valid_o}, 32'd1);
        chk("post_rst_head_addr",  addr_o, RST_A);
        chk("post_rst_head_data",  rdata_o, 32'hA000_0040);
        ready_i = 1'b1;
        for (int i = 0; i < 6; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
